spi_slave_responder: RTL
========================

Name: spi_slave_responder

Overview:
Standalone SPI target (slave) that answers an SPI master such as spi_module configured as master. It oversamples SCK/SS/MOSI on the system clock, shifts one DATA_W-bit word per frame in each direction, and supports all four CPOL/CPHA modes plus MSB/LSB-first ordering. It exposes a one-deep TX holding register with a valid/ready handshake and an RX register with valid/ack and overrun detection.

Parameters:
DATA_W, 8, word width in bits (4..32)
SYNC_STAGES, 2, flip-flop synchronizer depth on i_SCK, i_SS, i_MOSI (>=2)
FILL, all ones, word shifted out when the TX holding register is empty at a load event

Ports:
i_sys_clk  in  1  system clock; all logic on the rising edge
i_sys_rst  in  1  reset, synchronous, active-high
i_spe  in  1  block enable; when 0 the bus is ignored and MISO is released
i_cpol  in  1  SCK idle level
i_cpha  in  1  0 = sample on leading edge; 1 = sample on trailing edge
i_lsbfe  in  1  1 = LSB first
i_tx_data  in  DATA_W  next word to transmit
i_tx_valid  in  1  write strobe for i_tx_data
o_tx_ready  out  1  holding register empty (= ~holding_full)
o_rx_data  out  DATA_W  last received word
o_rx_valid  out  1  o_rx_data valid; held until i_rx_ack
i_rx_ack  in  1  consumes o_rx_data
o_overrun  out  1  sticky; a word completed while o_rx_valid=1
i_ovr_clr  in  1  clears o_overrun
o_underrun  out  1  sticky; FILL was loaded because holding was empty; cleared by i_ovr_clr
i_SCK  in  1  serial clock from master
i_SS  in  1  slave select, active low
i_MOSI  in  1  serial data in
o_MISO  out  1  serial data out
o_MISO_oe  out  1  output enable for MISO pad (1 = drive)

Behaviour:
- Reset values: o_tx_ready=1, o_rx_data=0, o_rx_valid=0, o_overrun=0, o_underrun=0, o_MISO=0, o_MISO_oe=0; holding register empty, bit counter 0, FSM in IDLE, synchronizers cleared to SCK=i_cpol, SS=1.
- SCK frequency must be <= f(i_sys_clk)/8. Edge detection uses the last two synchronized samples.
- Leading edge: SCK transition away from the i_cpol level. Trailing edge: transition back to it. Sample edge = leading if i_cpha=0, else trailing. Drive edge = the other one.
- FSM states:
  - IDLE: SS high or i_spe=0. On synchronized SS falling with i_spe=1, go to ACTIVE. If i_cpha=0, perform a load event in the same cycle.
  - ACTIVE: o_MISO_oe=1 and o_MISO = shift-register MSB (LSB if i_lsbfe).
    - Sample edge: capture MOSI into the RX shift register; bit_cnt++.
    - Drive edge: shift TX, except when a load event applies.
    - Load events: CPHA=1, leading edge with bit_cnt=0. CPHA=0, trailing edge following completion of a word.
    - When bit_cnt reaches DATA_W: go to DONE.
  - DONE (one cycle): deliver the word, clear bit_cnt, return to ACTIVE. If SS is high, go to IDLE instead.
- Delivery: if o_rx_valid=0, latch o_rx_data and set o_rx_valid. Otherwise set o_overrun and leave o_rx_data unchanged.
- i_rx_ack clears o_rx_valid in the next cycle. If ack and delivery occur in the same cycle, the new word is latched, o_rx_valid stays 1, and there is no overrun.
- Latency: o_rx_valid rises SYNC_STAGES+2 sys clocks after the final sample edge at the pin.
- Load event: copy the holding register into the TX shift register and mark holding empty. If holding is empty, load FILL and set o_underrun. A write in the same cycle as a load into empty holding is accepted and kept for the next word; it does not replace FILL.
- A write is accepted when i_tx_valid and o_tx_ready are both 1; o_tx_ready falls the next cycle.
- i_ovr_clr clears o_overrun and o_underrun. If a set and a clear coincide, the set wins.
- SS rising mid-word: abort and go to IDLE, clear bit_cnt. There is no delivery, the partial RX word is discarded, and the loaded TX word is lost. o_MISO_oe falls the cycle after the synchronized SS rise.
- Changing i_cpol, i_cpha or i_lsbfe while ACTIVE is undefined; the bench must not do this.
- i_spe falling while ACTIVE: treated as an abort.

Optional Feature:
SPI_SLV_IRQ_EN
- Defined: adds output o_interrupt, 1 bit, registered. It is high while (o_rx_valid | o_overrun | o_underrun) and reset value is 0.
- Not defined: the port does not exist and no logic is generated.

Test Plan:
- Mode 0, MSB first: write 0xA5 to holding, master sends 0x3C → o_rx_data=0x3C with o_rx_valid=1 after SYNC_STAGES+2 cycles; master receives 0xA5; o_tx_ready=1 again after the load.
- Mode 3, LSB first, i_cpol=1 i_cpha=1: holding 0x81, master sends 0x7E → o_rx_data=0x7E; MISO bit sequence 1,0,0,0,0,0,0,1.
- No TX write, master sends 0x55 → master receives 0xFF; o_underrun=1; i_ovr_clr pulse → o_underrun=0.
- Two back-to-back words 0x11 then 0x22 within one SS-low burst, no i_rx_ack → o_rx_data=0x11, o_overrun=1 after the second word; ack then a third word 0x33 → o_rx_data=0x33.
- SS raised after 5 SCK cycles → o_rx_valid stays 0; o_MISO_oe=0; next full frame 0x96 is received correctly.
- i_sys_rst asserted mid-frame for one cycle → all outputs return to reset values; holding empties (o_tx_ready=1).

Source files
------------

// File: rtl/spi_slave_responder.sv
// SPI target: oversampled SCK/SS/MOSI, one DATA_W word per frame each way, all CPOL/CPHA modes.
// Define SPI_SLV_IRQ_EN to add a registered o_interrupt output.
module spi_slave_responder #(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] FILL        = '1
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_spe,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic              i_lsbfe,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ack,
  output logic              o_overrun,
  input  logic              i_ovr_clr,
  output logic              o_underrun,
  input  logic              i_SCK,
  input  logic              i_SS,
  input  logic              i_MOSI,
  output logic              o_MISO,
  output logic              o_MISO_oe
`ifdef SPI_SLV_IRQ_EN
  ,output logic             o_interrupt
`endif
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   ss_prev_q, ss_prev_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]      tx_sr_q, tx_sr_d;
  logic                   word_done_q, word_done_d;
  logic [DATA_W-1:0]      hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   underrun_q, underrun_d;
  logic                   miso_q, miso_d;
  logic                   miso_oe_q, miso_oe_d;

  logic sck_s, ss_s, mosi_s;
  logic lead_edge, trail_edge, samp_edge, drv_edge, ss_fall, load;

  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign ss_s       = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign lead_edge  = (sck_s != sck_prev_q) && (sck_prev_q == i_cpol);
  assign trail_edge = (sck_s != sck_prev_q) && (sck_s == i_cpol);
  assign samp_edge  = i_cpha ? trail_edge : lead_edge;
  assign drv_edge   = i_cpha ? lead_edge  : trail_edge;
  assign ss_fall    = ss_prev_q && !ss_s;

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], i_SCK};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], i_SS};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_MOSI};
    sck_prev_d  = sck_s;
    ss_prev_d   = ss_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    word_done_d = word_done_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    underrun_d  = underrun_q;
    load        = 1'b0;

    if (i_rx_ack)  rx_valid_d = 1'b0;
    if (i_ovr_clr) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        bit_cnt_d   = '0;
        word_done_d = 1'b0;
        if (ss_fall && i_spe) begin
          state_d = ACTIVE;
          load    = !i_cpha;
        end
      end
      ACTIVE: begin
        if (ss_s || !i_spe) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else begin
          if (samp_edge) begin
            rx_sr_d   = i_lsbfe ? {mosi_s, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], mosi_s};
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (bit_cnt_d == CW'(DATA_W)) state_d = DONE;
          end
          // CPHA=1 loads on the first leading edge; CPHA=0 on the trailing edge after a word.
          if (drv_edge) begin
            if (i_cpha ? (bit_cnt_q == '0) : word_done_q) begin
              load        = 1'b1;
              word_done_d = 1'b0;
            end else begin
              tx_sr_d = i_lsbfe ? {1'b0, tx_sr_q[DATA_W-1:1]} : {tx_sr_q[DATA_W-2:0], 1'b0};
            end
          end
        end
      end
      DONE: begin
        if (!rx_valid_q || i_rx_ack) begin
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        bit_cnt_d   = '0;
        word_done_d = 1'b1;
        state_d     = (ss_s || !i_spe) ? IDLE : ACTIVE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      if (hold_full_q) begin
        tx_sr_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_sr_d    = FILL;
        underrun_d = 1'b1;
      end
    end
    // A write into empty holding coinciding with a FILL load is kept for the next word.
    if (i_tx_valid && !hold_full_q) begin
      hold_d      = i_tx_data;
      hold_full_d = 1'b1;
    end

    miso_oe_d = (state_d != IDLE);
    miso_d    = miso_oe_d && (i_lsbfe ? tx_sr_d[0] : tx_sr_d[DATA_W-1]);
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q     <= IDLE;
      sck_sync_q  <= {SYNC_STAGES{i_cpol}};
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= i_cpol;
      ss_prev_q   <= 1'b1;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      word_done_q <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      ss_prev_q   <= ss_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      word_done_q <= word_done_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
    end
  end

  assign o_tx_ready = !hold_full_q;
  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_overrun  = overrun_q;
  assign o_underrun = underrun_q;
  assign o_MISO     = miso_q;
  assign o_MISO_oe  = miso_oe_q;

`ifdef SPI_SLV_IRQ_EN
  logic irq_q, irq_d;
  assign irq_d = rx_valid_d || overrun_d || underrun_d;
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) irq_q <= 1'b0;
    else           irq_q <= irq_d;
  end
  assign o_interrupt = irq_q;
`endif

endmodule
